// File: rtl/digit_serial_adder.sv
// digit_serial_adder: adds or subtracts two WIDTH-bit operands DIGIT bits
// per clock, LSB digit first, with a registered carry between digits.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_carry,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0)
    begin : g_bad_params
      $error("digit_serial_adder: need 1<=DIGIT<=WIDTH, WIDTH%%DIGIT==0");
    end
  endgenerate

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MASK = WIDTH'({DIGIT{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [KW-1:0]    k_q, k_d;
  logic             c_q, c_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_x;
  logic [DIGIT-1:0] dig_y;
  logic [DIGIT:0]   dig_s;
  logic [WIDTH-1:0] acc_nxt;
  int               base;

  // One digit of the ripple: slice k of X and Y' plus the carry register.
  always_comb begin
    base    = DIGIT * int'(k_q);
    dig_x   = DIGIT'(x_q >> base);
    dig_y   = DIGIT'(y_q >> base);
    dig_s   = {1'b0, dig_x} + {1'b0, dig_y} + {{DIGIT{1'b0}}, c_q};
    acc_nxt = (acc_q & ~(MASK << base))
            | (WIDTH'(dig_s[DIGIT-1:0]) << base);
  end

  // Next-state: accept in IDLE/DONE, step digits in RUN, publish at the end.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    k_d     = k_q;
    c_d     = c_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        busy_d = 1'b0;
        if (i_start) begin
          x_d     = i_x;
          y_d     = i_sub ? ~i_y : i_y;
          c_d     = i_carry ^ i_sub;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = acc_nxt;
        c_d   = dig_s[DIGIT];
        k_d   = k_q + 1'b1;
        if (k_q == KW'(N - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = acc_nxt;
          carry_d = dig_s[DIGIT];
          ovf_d   = (x_q[WIDTH-1] == y_q[WIDTH-1])
                 && (acc_nxt[WIDTH-1] != x_q[WIDTH-1]);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_sum      = sum_q;
  assign o_carry    = carry_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: four instances (DIGIT 4, 1, 2, 16) against an
// integer-arithmetic reference model.
module tb_digit_serial_adder;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [3:0]  start_v;
  logic        i_sub;
  logic [15:0] i_x;
  logic [15:0] i_y;
  logic        i_carry;

  logic        busy[4];
  logic        done[4];
  logic        cout[4];
  logic        ovf[4];
  logic [15:0] sum[4];

  int          n_of[4] = '{4, 16, 8, 1};
  logic [17:0] prev[4];
  int          checks = 0;
  int          passed = 0;

  always #5 i_clk = ~i_clk;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(start_v[0]), .i_sub(i_sub),
    .i_x(i_x), .i_y(i_y), .i_carry(i_carry),
    .o_busy(busy[0]), .o_done(done[0]), .o_sum(sum[0]),
    .o_carry(cout[0]), .o_overflow(ovf[0]));

  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(start_v[1]), .i_sub(i_sub),
    .i_x(i_x), .i_y(i_y), .i_carry(i_carry),
    .o_busy(busy[1]), .o_done(done[1]), .o_sum(sum[1]),
    .o_carry(cout[1]), .o_overflow(ovf[1]));

  digit_serial_adder #(.WIDTH(16), .DIGIT(2)) u_d2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(start_v[2]), .i_sub(i_sub),
    .i_x(i_x), .i_y(i_y), .i_carry(i_carry),
    .o_busy(busy[2]), .o_done(done[2]), .o_sum(sum[2]),
    .o_carry(cout[2]), .o_overflow(ovf[2]));

  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(start_v[3]), .i_sub(i_sub),
    .i_x(i_x), .i_y(i_y), .i_carry(i_carry),
    .o_busy(busy[3]), .o_done(done[3]), .o_sum(sum[3]),
    .o_carry(cout[3]), .o_overflow(ovf[3]));

  // Reference: plain integer arithmetic; returns {overflow, carry, sum}.
  function automatic logic [17:0] ref_op(input logic [15:0] x,
                                         input logic [15:0] y,
                                         input logic sub,
                                         input logic cin);
    int ux, uy, sx, sy, r, sr;
    logic c, o;
    logic [15:0] s;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sub) begin
      r  = ux - uy - int'(cin);
      sr = sx - sy - int'(cin);
      c  = (r >= 0);
    end else begin
      r  = ux + uy + int'(cin);
      sr = sx + sy + int'(cin);
      c  = (r > 65535);
    end
    s = r[15:0];
    o = (sr > 32767) || (sr < -32768);
    return {o, c, s};
  endfunction

  // One operation on all four instances, junk inputs and start pulses
  // while each instance is still running, cycle-by-cycle output checks.
  task automatic do_op(input logic [15:0] x, input logic [15:0] y,
                       input logic sub, input logic cin, input string nm);
    logic [17:0] e[4];
    logic [19:0] act, want;
    for (int j = 0; j < 4; j++) e[j] = ref_op(x, y, sub, cin);
    i_x = x;
    i_y = y;
    i_sub = sub;
    i_carry = cin;
    start_v = 4'hF;
    for (int c = 0; c <= 17; c++) begin
      if (c > 0) begin
        i_x = 16'($urandom);
        i_y = 16'($urandom);
        i_sub = 1'($urandom);
        i_carry = 1'($urandom);
        for (int j = 0; j < 4; j++)
          start_v[j] = (c <= n_of[j]) ? 1'($urandom) : 1'b0;
      end
      @(posedge i_clk);
      #1;
      for (int j = 0; j < 4; j++) begin
        act = {busy[j], done[j], ovf[j], cout[j], sum[j]};
        if (c < n_of[j]) want = {2'b10, prev[j]};
        else if (c == n_of[j]) want = {2'b01, e[j]};
        else want = {2'b00, e[j]};
        checks++;
        if (act !== want)
          $display("FAIL %s inst%0d cyc%0d {busy,done,ovf,cy,sum}: got %h want %h",
                   nm, j, c, act, want);
        else passed++;
      end
    end
    start_v = 4'h0;
    for (int j = 0; j < 4; j++) prev[j] = e[j];
  endtask

  task automatic test_reset;
    logic [19:0] act;
    i_rst = 1'b1;
    start_v = 4'h0;
    i_x = '0;
    i_y = '0;
    i_sub = 1'b0;
    i_carry = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    for (int j = 0; j < 4; j++) begin
      act = {busy[j], done[j], ovf[j], cout[j], sum[j]};
      checks++;
      if (act !== 20'h0) $display("FAIL reset_state inst%0d: got %h want 0", j, act);
      else passed++;
    end
    i_rst = 1'b0;
    for (int j = 0; j < 4; j++) prev[j] = '0;
    do_op(16'h1234, 16'h4321, 1'b0, 1'b1, "pre_reset");
    start_v = 4'b0111;
    i_x = 16'hAAAA;
    i_y = 16'h5555;
    @(posedge i_clk);
    #1;
    start_v = 4'h0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    repeat (2) begin
      @(posedge i_clk);
      #1;
      for (int j = 0; j < 4; j++) begin
        act = {busy[j], done[j], ovf[j], cout[j], sum[j]};
        checks++;
        if (act !== 20'h0) $display("FAIL reset_midrun inst%0d: got %h want 0", j, act);
        else passed++;
      end
    end
    i_rst = 1'b0;
    repeat (20) begin
      @(posedge i_clk);
      #1;
      for (int j = 0; j < 4; j++) begin
        act = {busy[j], done[j], ovf[j], cout[j], sum[j]};
        checks++;
        if (act !== 20'h0) $display("FAIL reset_no_done inst%0d: got %h want 0", j, act);
        else passed++;
      end
    end
    for (int j = 0; j < 4; j++) prev[j] = '0;
  endtask

  task automatic test_add_wrap;
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_wrap");
    checks++;
    if ({ovf[0], cout[0], sum[0]} !== 18'h10000)
      $display("FAIL add_wrap_const: got %h want 10000", {ovf[0], cout[0], sum[0]});
    else passed++;
  endtask

  task automatic test_overflow;
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "overflow");
    checks++;
    if ({ovf[0], cout[0], sum[0]} !== 18'h28000)
      $display("FAIL overflow_const: got %h want 28000", {ovf[0], cout[0], sum[0]});
    else passed++;
  endtask

  task automatic test_subtract;
    do_op(16'h0003, 16'h0005, 1'b1, 1'b0, "sub_borrow");
    checks++;
    if ({cout[0], sum[0]} !== 17'h0FFFE)
      $display("FAIL sub_borrow_const: got %h want 0fffe", {cout[0], sum[0]});
    else passed++;
    do_op(16'h0005, 16'h0003, 1'b1, 1'b1, "sub_noborrow");
    checks++;
    if ({cout[0], sum[0]} !== 17'h10001)
      $display("FAIL sub_noborrow_const: got %h want 10001", {cout[0], sum[0]});
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] xs[6];
    logic [15:0] ys[6];
    logic        ss[6];
    logic        cs[6];
    logic [17:0] e;
    logic [19:0] act, want;
    for (int i = 0; i < 6; i++) begin
      xs[i] = 16'($urandom);
      ys[i] = 16'($urandom);
      ss[i] = 1'($urandom);
      cs[i] = 1'($urandom);
    end
    i_x = xs[0];
    i_y = ys[0];
    i_sub = ss[0];
    i_carry = cs[0];
    start_v = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      e = ref_op(xs[i], ys[i], ss[i], cs[i]);
      @(posedge i_clk);
      #1;
      act = {busy[0], done[0], ovf[0], cout[0], sum[0]};
      want = {2'b10, prev[0]};
      checks++;
      if (act !== want) $display("FAIL b2b_accept op%0d: got %h want %h", i, act, want);
      else passed++;
      for (int c = 1; c <= 4; c++) begin
        i_x = 16'($urandom);
        i_y = 16'($urandom);
        i_sub = 1'($urandom);
        i_carry = 1'($urandom);
        @(posedge i_clk);
        #1;
        act = {busy[0], done[0], ovf[0], cout[0], sum[0]};
        want = (c < 4) ? {2'b10, prev[0]} : {2'b01, e};
        checks++;
        if (act !== want)
          $display("FAIL b2b_run op%0d cyc%0d: got %h want %h", i, c, act, want);
        else passed++;
      end
      prev[0] = e;
      if (i < 5) begin
        i_x = xs[i+1];
        i_y = ys[i+1];
        i_sub = ss[i+1];
        i_carry = cs[i+1];
      end else begin
        start_v = 4'h0;
      end
    end
    @(posedge i_clk);
    #1;
    act = {busy[0], done[0], ovf[0], cout[0], sum[0]};
    want = {2'b00, prev[0]};
    checks++;
    if (act !== want) $display("FAIL b2b_idle: got %h want %h", act, want);
    else passed++;
  endtask

  task automatic test_random_sweep;
    for (int i = 0; i < 1000; i++)
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "sweep");
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_overflow();
    test_subtract();
    test_back_to_back();
    test_random_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised, multi-cycle successor to the single-bit full adder cell. It adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB digit first, with a registered carry chained between digits. A start/busy/done handshake frames each operation. It serves datapaths where area matters more than latency, and the WIDTH/DIGIT trade-off is selected at instantiation.

## Interface

Parameters:
- WIDTH, default 16: operand and result width in bits. Must be ≥ 1.
- DIGIT, default 4: bits processed per clock. Must satisfy 1 ≤ DIGIT ≤ WIDTH and WIDTH % DIGIT == 0. Elaboration fails otherwise.
- Derived N = WIDTH/DIGIT: digits per operation.

Ports:
- i_clk, input, 1: sole clock. Rising edge.
- i_rst, input, 1: reset, synchronous, active-high.
- i_start, input, 1: request a new operation. Sampled only in IDLE or DONE.
- i_sub, input, 1: 0 = add, 1 = subtract. Sampled with i_start.
- i_x, input, WIDTH: operand X. Sampled with i_start.
- i_y, input, WIDTH: operand Y. Sampled with i_start.
- i_carry, input, 1: carry-in. Sampled with i_start.
- o_busy, output, 1: high while digits are being processed (RUN).
- o_done, output, 1: one-cycle pulse; results valid.
- o_sum, output, WIDTH: result. Held until the next accepted start.
- o_carry, output, 1: final carry-out. Held like o_sum.
- o_overflow, output, 1: signed two's-complement overflow. Held like o_sum.

## Operation

- States: IDLE, RUN, DONE.
- IDLE: start accepted when i_start=1.
  - Latch X.
  - Latch Y' = i_sub ? ~i_y : i_y.
  - Set carry register c = i_carry ^ i_sub.
  - Clear digit counter k = 0; go to RUN.
- RUN: each edge computes {c, d} = X[k] + Y'[k] + c on DIGIT-bit slice k.
  - d is written to result slice k. Implementation may be a shift register or an indexed write.
  - k increments each edge.
  - On the edge with k = N−1: go to DONE.
  - Also on that edge: o_carry = final c; o_overflow = (X[msb] == Y'[msb]) && (sum[msb] != X[msb]).
- DONE: o_done=1 for exactly one cycle.
  - i_start=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise return to IDLE.
- i_start in RUN is ignored. Operand/mode changes in RUN have no effect.
- Arithmetic results:
  - Add: o_sum = (X + Y + i_carry) mod 2^WIDTH; o_carry = bit WIDTH of that sum.
  - Subtract: o_sum = (X − Y − i_carry) mod 2^WIDTH; o_carry = 1 means no borrow. i_carry acts as a borrow-in.
- o_sum, o_carry and o_overflow update only on the final RUN edge. Intermediate digits may appear in internal registers but never on o_sum.
- DIGIT = WIDTH (N = 1): one RUN cycle; behaves as a registered full-width adder.
- DIGIT = 1: pure bit-serial; N = WIDTH RUN cycles.

## Timing

- Reset value of every output is 0: o_busy, o_done, o_sum, o_carry, o_overflow. State returns to IDLE.
- Reset applies at the next rising edge with i_rst=1 and has priority over i_start.
- Reset mid-RUN aborts the operation: no o_done, outputs cleared.
- Start sampled at edge E0:
  - o_busy=1 from E0 through EN, i.e. N cycles.
  - o_done=1 in the cycle after edge EN.
  - Latency from start edge to o_done is N cycles.
- Throughput with i_start held high: one result every N+1 cycles.
  - o_busy goes low for exactly the DONE cycle.
  - o_done and o_busy are never high together.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

All scenarios use WIDTH=16, DIGIT=4, N=4.

- Reset: assert i_rst for 2 cycles mid-RUN → all outputs 0, no o_done pulse, state IDLE. A subsequent start works normally.
- Add with wrap: X=0xFFFF, Y=0x0001, c=0, sub=0 → o_done exactly 4 cycles after start edge; o_sum=0x0000, o_carry=1, o_overflow=0.
- Signed overflow: X=0x7FFF, Y=0x0001, add → o_sum=0x8000, o_carry=0, o_overflow=1.
- Subtract with borrow: X=0x0003, Y=0x0005, i_carry=0, sub=1 → o_sum=0xFFFE, o_carry=0. Then X=0x0005, Y=0x0003, i_carry=1 → o_sum=0x0001, o_carry=1.
- Back-to-back and ignored start: hold i_start=1 with new operands each DONE cycle → o_done every 5 cycles with correct sums. Operand/start toggles during RUN do not alter the in-flight result. o_sum holds its value between operations.
- Parameter sweep: DIGIT ∈ {1, 2, 16} with 1000 random operand/mode/carry triples → results match the reference model; o_done latency equals WIDTH/DIGIT.
